ahb_slave_port_arb: RTL

Slave-side arbiter and request multiplexer for one slave port of the multilayer AHB-Lite interconnect. It is the forward-direction counterpart of the per-master response mux. Several masters may address the same slave; this block round-robin arbitrates their address phases and forwards the winner's address/control to the slave. It tracks which master owns the current data phase, so that master's HWDATA goes to the slave and the response-side mux gets a one-hot data-phase select. Losing masters are stalled through their HREADY.

---
 rtl/ahb_slave_port_arb.sv | 115 +++++++++++
 1 files changed

// File: rtl/ahb_slave_port_arb.sv
// Slave-side round-robin arbiter and request mux for one AHB-Lite slave port.
// It forwards the winning master's address phase and routes the data-phase owner's HWDATA.
module ahb_slave_port_arb #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [NUM_MASTERS-1:0] i_mhsel,
    input  logic [ADDR_WIDTH-1:0]  i_mhaddr  [NUM_MASTERS],
    input  logic [1:0]             i_mhtrans [NUM_MASTERS],
    input  logic                   i_mhwrite [NUM_MASTERS],
    input  logic [2:0]             i_mhsize  [NUM_MASTERS],
    input  logic [DATA_WIDTH-1:0]  i_mhwdata [NUM_MASTERS],
    input  logic                   i_shreadyout,
    output logic                   o_shsel,
    output logic [ADDR_WIDTH-1:0]  o_shaddr,
    output logic [1:0]             o_shtrans,
    output logic                   o_shwrite,
    output logic [2:0]             o_shsize,
    output logic [DATA_WIDTH-1:0]  o_shwdata,
    output logic                   o_shready,
    output logic [NUM_MASTERS-1:0] o_mhready,
    output logic [NUM_MASTERS-1:0] o_dp_sel
);

    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam logic [1:0] TRANS_IDLE = 2'b00;
    localparam logic [1:0] TRANS_BUSY = 2'b01;
    localparam logic [1:0] TRANS_SEQ  = 2'b11;

    logic [IDX_W-1:0]       ao_owner, dp_owner, rr_ptr, grant;
    logic                   ao_valid, dp_valid, grant_valid, lock;
    logic [IDX_W:0]         pick;
    logic [NUM_MASTERS-1:0] req, dp_sel;

    // Nearest requester after ptr wins: scan far-to-near so the closest overwrites.
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_MASTERS-1:0] r,
                                               input logic [IDX_W-1:0] ptr);
        logic [IDX_W:0]   res;
        logic [IDX_W-1:0] idx;
        res = '0;
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            idx = IDX_W'((int'(ptr) + k) % NUM_MASTERS);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    for (genvar m = 0; m < NUM_MASTERS; m++) begin : g_req
        assign req[m] = i_mhsel[m] & i_mhtrans[m][1];
    end

    // A locked owner keeps the bus while it continues its burst with SEQ or BUSY.
    assign lock = ao_valid & i_mhsel[ao_owner] &
                  ((i_mhtrans[ao_owner] == TRANS_SEQ) | (i_mhtrans[ao_owner] == TRANS_BUSY));
    assign pick = rr_pick(req, rr_ptr);

    always_comb begin
        grant       = ao_owner;
        grant_valid = ao_valid;
        if (i_shreadyout) begin
            if (lock) begin
                grant       = ao_owner;
                grant_valid = 1'b1;
            end else begin
                grant       = pick[IDX_W-1:0];
                grant_valid = pick[IDX_W];
            end
        end
    end

    always_comb begin
        o_shsel   = grant_valid;
        o_shaddr  = '0;
        o_shtrans = TRANS_IDLE;
        o_shwrite = 1'b0;
        o_shsize  = 3'd0;
        if (grant_valid) begin
            o_shaddr  = i_mhaddr[grant];
            o_shtrans = i_mhtrans[grant];
            o_shwrite = i_mhwrite[grant];
            o_shsize  = i_mhsize[grant];
        end
    end

    assign o_shready = i_shreadyout;
    assign o_shwdata = dp_valid ? i_mhwdata[dp_owner] : '0;
    assign o_dp_sel  = dp_sel;

    // Data-phase owner sees the slave's ready; a losing requester is stalled.
    for (genvar m = 0; m < NUM_MASTERS; m++) begin : g_mready
        assign dp_sel[m]    = dp_valid & (dp_owner == IDX_W'(m));
        assign o_mhready[m] = dp_sel[m] ? i_shreadyout :
                              !(req[m] & !(grant_valid & (grant == IDX_W'(m))));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ao_owner <= '0;
            ao_valid <= 1'b0;
            dp_owner <= '0;
            dp_valid <= 1'b0;
            rr_ptr   <= '0;
        end else if (i_shreadyout) begin
            ao_owner <= grant;
            ao_valid <= grant_valid;
            dp_owner <= grant;
            dp_valid <= grant_valid & (o_shtrans != TRANS_BUSY);
            if (grant_valid) rr_ptr <= grant;
        end
    end

endmodule
